ok_buffered_pipe_out: RTL
=========================

OK_BUFFERED_PIPE_OUT -- requirements
Module: ok_buffered_pipe_out

Interface
REQ-001 The block SHALL have parameter EP_ADDR, default 8'hA0: pipe-out endpoint address matched against ti_addr.
REQ-002 The block SHALL have parameter DEPTH, default 1024: FIFO depth in 32-bit words; power of two, at least 2.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 256: word threshold for pipe_ready; range 1..DEPTH.
REQ-004 The block SHALL have parameter FILL_WORD, default 32'hDEADBEEF: word returned on a read from an empty FIFO.
REQ-005 The block SHALL have port okClk, input, 1 bit: single clock for all logic; one clock, no CDC inside.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port okHE, input, 113 bits: host-to-endpoint bus; ti_addr and ti_read are taken from it using the team mapping include.
REQ-008 The block SHALL have port okEH, output, 65 bits: endpoint-to-host bus carrying data, ready and regreaddata fields.
REQ-009 The block SHALL have port din, input, 32 bits: user write data.
REQ-010 The block SHALL have port din_valid, input, 1 bit: user write request.
REQ-011 The block SHALL have port din_ready, output, 1 bit: FIFO can accept a word.
REQ-012 The block SHALL have port flush, input, 1 bit: synchronous FIFO clear.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have port pipe_ready, output, 1 bit: count >= BLOCK_SIZE, for host block-pipe polling.
REQ-015 The block SHALL have port underflow, output, 1 bit: sticky flag, set on any read of an empty FIFO.
REQ-016 The block SHALL have port underflow_cnt, output, 16 bits: saturating count of empty reads.

Function
REQ-017 The FIFO SHALL be a circular buffer with write pointer, read pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-018 din_ready SHALL equal (count != DEPTH) and SHALL be 0 while reset is asserted.
REQ-019 A write SHALL occur on a rising okClk edge with din_valid=1 and din_ready=1; din_valid with din_ready=0 is ignored and no data is stored.
REQ-020 Endpoint select SHALL be sel = (ti_addr == EP_ADDR).
REQ-021 okEH data SHALL be the head word when sel=1 and count!=0, FILL_WORD when sel=1 and count==0, and 0 when sel=0.
REQ-022 okEH ready SHALL equal sel; okEH regreaddata SHALL be constant 0.
REQ-023 The read strobe SHALL be rd = ti_read AND sel.
REQ-024 When rd=1 and count!=0, the read pointer SHALL advance at the next edge.
REQ-025 When rd=1 and count==0, no pop SHALL occur, underflow SHALL be set, and underflow_cnt SHALL increment, saturating at 16'hFFFF.
REQ-026 Write-to-visibility latency SHALL be 1 cycle: a word written at edge t appears at the head (if FIFO was empty) and in count after edge t.
REQ-027 Simultaneous read and write with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-028 Read and write in the same cycle when full SHALL pop only; the write is refused because din_ready=0, and there is no bypass.
REQ-029 Read and write in the same cycle when empty SHALL accept the write and flag underflow; count becomes 1 and the host receives FILL_WORD that cycle.
REQ-030 flush=1 SHALL zero both pointers and count at the next edge, with priority over reads and writes in the same cycle; underflow and underflow_cnt are unaffected.
REQ-031 pipe_ready SHALL be combinational from the registered count.
REQ-032 Occupancy SHALL never exceed DEPTH or go below 0 under any input sequence.

Reset
REQ-033 Asserting reset SHALL immediately force both pointers, count, underflow and underflow_cnt to 0; pipe_ready=0 and din_ready=0.
REQ-034 FIFO storage contents are don't-care after reset.
REQ-035 Reset asserted mid-transfer SHALL discard all stored words; the first read after reset returns FILL_WORD.
REQ-036 After reset deasserts, din_ready SHALL be 1 from the first active edge.

Verification
REQ-037 Scenario 1: write 0x1,0x2,0x3, then 3 host reads at EP_ADDR -> data 0x1,0x2,0x3 in order, count 3->0, underflow=0.
REQ-038 Scenario 2: fill DEPTH words -> din_ready=0 and count=DEPTH; a further din_valid is dropped; one read -> din_ready=1 next cycle.
REQ-039 Scenario 3: read from empty FIFO 3 times -> data FILL_WORD each time, underflow=1, underflow_cnt=3; force 65540 empty reads -> underflow_cnt=0xFFFF.
REQ-040 Scenario 4: with BLOCK_SIZE=4, write 3 words -> pipe_ready=0; write a 4th -> pipe_ready=1; ti_addr!=EP_ADDR with ti_read=1 -> data 0, ready 0, no pop.
REQ-041 Scenario 5: simultaneous read and write at count=5 -> count stays 5; flush with simultaneous write -> count=0.
REQ-042 Scenario 6: assert reset asynchronously, between edges, with 10 words stored -> count=0 without waiting for a clock edge; next read returns FILL_WORD.

Source files
------------

// File: rtl/ok_buffered_pipe_out_if.sv
// Host-bus and user write-side signals of the buffered pipe-out endpoint.
// master = host/user side that drives the bus; slave = the endpoint.
interface ok_buffered_pipe_out_if;
  logic [112:0] okHE;
  logic [64:0]  okEH;
  logic [31:0]  din;
  logic         din_valid;
  logic         din_ready;
  logic         flush;

  modport master (
    output okHE, din, din_valid, flush,
    input  okEH, din_ready
  );

  modport slave (
    input  okHE, din, din_valid, flush,
    output okEH, din_ready
  );
endinterface

// File: rtl/ok_buffered_pipe_out.sv
// Buffered pipe-out endpoint: user words are pushed into a circular FIFO and
// drained by host reads at EP_ADDR; an empty read returns FILL_WORD and is counted.
module ok_buffered_pipe_out #(
  parameter logic [7:0]  EP_ADDR    = 8'hA0,
  parameter int          DEPTH      = 1024,
  parameter int          BLOCK_SIZE = 256,
  parameter logic [31:0] FILL_WORD  = 32'hDEADBEEF
) (
  input  logic                     okClk,
  input  logic                     reset,
  ok_buffered_pipe_out_if.slave    bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pipe_ready,
  output logic                     underflow,
  output logic [15:0]              underflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // okHE field positions: ti_read at bit 3, ti_addr at bits 11:4
  localparam int TI_READ     = 3;
  localparam int TI_ADDR_LSB = 4;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    ti_addr;
  logic          ti_read;
  logic          sel;
  logic          rd;
  logic          empty;
  logic          push;
  logic          pop;
  logic [31:0]   data_out;
  logic          unused_he;

  assign ti_addr   = bus.okHE[TI_ADDR_LSB +: 8];
  assign ti_read   = bus.okHE[TI_READ];
  assign unused_he = ^{bus.okHE[112:12], bus.okHE[2:0]};

  assign sel   = (ti_addr == EP_ADDR);
  assign rd    = ti_read & sel;
  assign empty = (count == '0);
  assign pop   = rd & ~empty;

  assign bus.din_ready = ~reset & (count != CW'(DEPTH));
  assign push          = bus.din_valid & bus.din_ready;

  assign pipe_ready = (count >= CW'(BLOCK_SIZE));

  always_comb begin
    data_out = '0;
    if (sel)
      data_out = empty ? FILL_WORD : mem[rd_ptr];
  end

  assign bus.okEH = {32'h0, sel, data_out};

  // Storage is not reset; flush wins over a same-cycle write.
  always_ff @(posedge okClk) begin
    if (push && !bus.flush)
      mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      // Underflow tracking is independent of flush.
      if (rd && empty) begin
        underflow <= 1'b1;
        if (underflow_cnt != 16'hFFFF)
          underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

endmodule
